// File: rtl/decoder_2x4_seq_pkg.sv
// decoder_2x4_seq_pkg: shared FSM states, mode encodings and one-hot decode constants
package decoder_2x4_seq_pkg;
  typedef enum logic [1:0] {IDLE, PASS, SCAN, DRAIN} state_t;
  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  localparam logic [3:0] OH_CODE0 = 4'b0001;
  localparam logic [3:0] OH_CODE1 = 4'b0010;
  localparam logic [3:0] OH_CODE2 = 4'b0100;
  localparam logic [3:0] OH_CODE3 = 4'b1000;
  function automatic logic [3:0] decode(input logic [1:0] code);
    return code == 2'd0 ? OH_CODE0 : code == 2'd1 ? OH_CODE1 : code == 2'd2 ? OH_CODE2 : OH_CODE3;
  endfunction
endpackage

// File: rtl/decoder_2x4_seq_if.sv
// decoder_2x4_seq_if: code input, decoded one-hot output and status signals
interface decoder_2x4_seq_if;
  logic a0, a1, in_valid, in_ready, mode;
  logic d0, d1, d2, d3, out_valid, out_ready, busy;
  modport slave (
    input  a0, a1, in_valid, mode, out_ready,
    output in_ready, d0, d1, d2, d3, out_valid, busy
  );
  modport master (
    output a0, a1, in_valid, mode, out_ready,
    input  in_ready, d0, d1, d2, d3, out_valid, busy
  );
endinterface

// File: rtl/decoder_2x4_seq_fifo.sv
// sync_fifo_onehot: DEPTH-entry FIFO of 4-bit one-hot words; head reads 0 when empty
module sync_fifo_onehot #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [3:0] i_data,
  input  logic       i_pop,
  output logic [3:0] o_data,
  output logic       o_empty,
  output logic       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  logic [3:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_empty = r_count == '0;
  assign o_full  = r_count == FULL_CNT;
  assign o_data  = o_empty ? 4'b0000 : r_mem[r_rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/decoder_2x4_seq.sv
// decoder_2x4_seq: 2-to-4 one-hot decoder with pass/scan modes feeding an output FIFO
module decoder_2x4_seq
  import decoder_2x4_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  decoder_2x4_seq_if.slave  bus
);
  state_t r_state, w_next;
  logic [1:0] r_scan;
  logic w_empty, w_full, w_pass_push, w_scan_push;
  logic [3:0] w_word, w_head;
  assign bus.in_ready = r_state == PASS && (!w_full || bus.out_ready);
  assign w_pass_push  = bus.in_valid && bus.in_ready;
  assign w_scan_push  = r_state == SCAN && !w_full;
  assign w_word       = decode(w_scan_push ? r_scan : {bus.a1, bus.a0});
  assign {bus.d3, bus.d2, bus.d1, bus.d0} = w_head;
  assign bus.out_valid = !w_empty;
  assign bus.busy      = r_state != IDLE || !w_empty;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.mode == MODE_SCAN ? SCAN : PASS;
      PASS:    w_next = bus.mode == MODE_SCAN ? DRAIN : PASS;
      SCAN:    w_next = bus.mode == MODE_PASS ? DRAIN : SCAN;
      default: w_next = !w_empty ? DRAIN : bus.mode == MODE_SCAN ? SCAN : PASS;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_scan  <= '0;
    end else begin
      r_state <= w_next;
      // the walking one always restarts from code 0 when scan is (re)entered
      if (w_next == SCAN && r_state != SCAN) r_scan <= '0;
      else if (w_scan_push) r_scan <= r_scan + 1'b1;
    end
  end
  sync_fifo_onehot #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_pass_push || w_scan_push),
    .i_data  (w_word),
    .i_pop   (bus.out_ready),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );
endmodule

// File: tb/tb_decoder_2x4_seq.sv
// tb_decoder_2x4_seq: randomized and directed checks against a queue-based reference model
module tb_decoder_2x4_seq;
  localparam int DEPTH = 2;
  typedef enum {M_IDLE, M_PASS, M_SCAN, M_DRAIN} mst_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic md = 1'b0, iv = 1'b0, ordy = 1'b0;
  logic [1:0] code = 2'd0;
  logic [6:0] obs;
  mst_t m_state = M_IDLE;
  int m_scan = 0;
  logic [3:0] q[$];
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  decoder_2x4_seq_if bus();
  decoder_2x4_seq #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.a0 = code[0];
  assign bus.a1 = code[1];
  assign bus.in_valid = iv;
  assign bus.out_ready = ordy;
  assign bus.mode = md;
  assign obs = {bus.in_ready, bus.out_valid, bus.busy, bus.d3, bus.d2, bus.d1, bus.d0};

  function automatic logic [6:0] exp_vec();
    logic ir, ov, bz;
    logic [3:0] head;
    ir = m_state == M_PASS && (q.size() < DEPTH || ordy);
    ov = q.size() > 0;
    bz = m_state != M_IDLE || q.size() > 0;
    head = ov ? q[0] : 4'b0000;
    return {ir, ov, bz, head};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_scan = 0;
    q.delete();
  endtask

  task automatic model_edge();
    int sz;
    bit push, pop;
    logic [3:0] w;
    mst_t prev;
    sz = q.size();
    pop = sz > 0 && ordy;
    push = 0;
    w = 4'b0000;
    prev = m_state;
    if (m_state == M_PASS && iv && (sz < DEPTH || ordy)) begin
      push = 1;
      w = 4'b0001 << code;
    end
    if (m_state == M_SCAN && sz < DEPTH) begin
      push = 1;
      w = 4'b0001 << m_scan;
      m_scan = (m_scan + 1) % 4;
    end
    case (m_state)
      M_IDLE:  m_state = md ? M_SCAN : M_PASS;
      M_PASS:  if (md) m_state = M_DRAIN;
      M_SCAN:  if (!md) m_state = M_DRAIN;
      M_DRAIN: if (sz == 0) m_state = md ? M_SCAN : M_PASS;
    endcase
    if (m_state == M_SCAN && prev != M_SCAN) m_scan = 0;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    md = 1'b0; iv = 1'b0; ordy = 1'b0; code = 2'd0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== 7'b0) begin n_fail++; $display("FAIL reset_hold: got %b want %b", obs, 7'b0); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs, exp_vec()); end
    tick();
    #1;
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_to_pass: got %b want %b", obs, exp_vec()); end
  endtask

  task automatic test_pass_seq();
    md = 1'b0; ordy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      iv = i < 4;
      code = 2'(i);
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL pass_seq cyc %0d: got %b want %b", i, obs, exp_vec()); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    md = 1'b0; ordy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      iv = i < 3;
      code = 2'(i);
      ordy = i >= 6;
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL backpressure cyc %0d: got %b want %b", i, obs, exp_vec()); end
      tick();
    end
  endtask

  task automatic test_full_pushpop();
    logic [1:0] codes [7];
    codes = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0};
    md = 1'b0;
    for (int i = 0; i < 7; i++) begin
      iv = i < 5;
      code = codes[i];
      ordy = i >= 2;
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL full_pushpop cyc %0d: got %b want %b", i, obs, exp_vec()); end
      tick();
    end
  endtask

  task automatic test_scan();
    md = 1'b1; iv = 1'b0; ordy = 1'b1;
    for (int i = 0; i < 14; i++) begin
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL scan cyc %0d: got %b want %b", i, obs, exp_vec()); end
      tick();
    end
  endtask

  task automatic test_mode_switch();
    md = 1'b0; ordy = 1'b1; iv = 1'b0;
    for (int i = 0; i < 10 && m_state != M_PASS; i++) tick();
    for (int i = 0; i < 12; i++) begin
      iv = i < 2;
      code = i == 0 ? 2'd2 : 2'd3;
      ordy = i >= 2;
      md = i >= 2;
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL mode_switch cyc %0d: got %b want %b", i, obs, exp_vec()); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    md = 1'b0; iv = 1'b0; ordy = 1'b1;
    for (int i = 0; i < 10 && m_state != M_PASS; i++) tick();
    ordy = 1'b0; iv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      code = 2'(i + 1);
      tick();
    end
    iv = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== 7'b0) begin n_fail++; $display("FAIL reset_mid_async: got %b want %b", obs, 7'b0); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_mid_after cyc %0d: got %b want %b", i, obs, exp_vec()); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      iv = 1'($urandom_range(0, 1));
      code = 2'($urandom_range(0, 3));
      ordy = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 24) == 0) md = ~md;
      #1;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_vec()); end
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pass_seq();
    test_backpressure();
    test_full_pushpop();
    test_scan();
    test_mode_switch();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
